ram_access_engine: RTL and testbench
====================================

# ram_access_engine

Command-driven initiator for the 8 x 11-bit dual-read/single-write RAM in the 5-bit CPU datapath. Accepts one command at a time (FILL, COPY, SUM) over a valid/ready handshake. Sequences the RAM's write port and both read ports cycle by cycle, then reports completion with a one-cycle `done` pulse and a sum result. It sits between the control unit or test harness and the RAM, and connects port-for-port to the RAM's write/read pins.

## Interface
- `DATA_W`, 11, RAM word width
- `ADDR_W`, 3, RAM address width (depth = 2^ADDR_W = 8)
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clk`
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  engine can accept a command (high only in IDLE)
- `cmd_op`  in  2  00 FILL, 01 COPY, 10 SUM, 11 reserved
- `cmd_src`  in  ADDR_W  source start address (COPY, SUM)
- `cmd_dst`  in  ADDR_W  destination start address (FILL, COPY)
- `cmd_len`  in  ADDR_W+1  word count, 0..8
- `cmd_data`  in  DATA_W  fill value (FILL)
- `Write_Enable`  out  1  RAM write strobe
- `Write_Address`  out  ADDR_W  RAM write address
- `Write_Data`  out  DATA_W  RAM write data
- `Read_Address_1`, `Read_Address_2`  out  ADDR_W  RAM read addresses
- `Read_Data_1`, `Read_Data_2`  in  DATA_W  RAM read data; combinational from the read addresses
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; high for a reserved op
- `result`  out  DATA_W+ADDR_W  SUM total (14 bits); held until the next accept

## Operation
- States: IDLE, RUN, DONE.
- Command capture:
  - In IDLE with `cmd_valid`=1, the command is accepted: all fields are latched, the index counter i is set to 0, and `result` is cleared.
  - Next state is RUN, except: `cmd_len`=0 goes to DONE (no RAM access), and op 11 goes to DONE with `err`=1 (no RAM access).
  - `cmd_len` values above 8 are clamped to 8.
- Address arithmetic: every address is start+i modulo 8, so ranges wrap from 7 to 0.
- FILL:
  - Each RUN cycle drives `Write_Enable`=1, `Write_Address`=dst+i, `Write_Data`=data.
  - Increments i by 1; after the cycle with i=len-1, goes to DONE.
- COPY:
  - Each RUN cycle drives `Read_Address_1`=src+i, `Write_Enable`=1, `Write_Address`=dst+i, `Write_Data`=`Read_Data_1`.
  - Increments i by 1. Words move in ascending order, one per cycle.
  - Overlapping ranges follow that order exactly. For example, src=0, dst=1, len=3 replicates word 0 into words 1..3.
- SUM:
  - Each RUN cycle drives `Read_Address_1`=src+i and `Read_Address_2`=src+i+1.
  - Adds `Read_Data_1`, plus `Read_Data_2` only if i+1 < len, into `result` (zero-extended, no overflow possible).
  - Increments i by 2. `Write_Enable`=0 throughout.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. `err` holds its value until the next accept.
- Outputs outside the active op's use:
  - `Write_Enable`=0 outside RUN for FILL/COPY.
  - Unused address/data outputs are driven to 0.
- `cmd_valid` while not in IDLE is ignored; `cmd_ready`=0 there.

## Timing
- Reset (`reset`=0 at a rising edge):
  - Next state is IDLE, and i, latched fields, `result`, `err`, `done`, and `busy` all become 0.
  - `cmd_ready` returns to 1 on the first cycle with `reset`=1.
- Reset write gating: `Write_Enable` is gated combinationally by `reset`. No RAM write commits on any edge where `reset`=0, including mid-RUN; words already written stay written.
- RAM-side outputs are combinational from state, counter and latched fields. A write for index i commits on the rising edge that ends that RUN cycle.
- Latency from accept edge to the `done` cycle:
  - FILL/COPY: len+1 cycles.
  - SUM: ceil(len/2)+1 cycles.
  - len=0 or reserved op: 1 cycle.
- Back-to-back: the earliest next accept is the cycle after `done`, since IDLE is re-entered with `cmd_ready`=1.
- `result` becomes final on the edge entering DONE and is stable while `done`=1.

## Test plan
- Reset then FILL dst=6 len=4 data=11'h5A5 -> RAM[6], RAM[7], RAM[0], RAM[1] = 11'h5A5 (wrap); other words unchanged; `done` 5 cycles after accept, `err`=0.
- Preload RAM[0..7]=1..8, SUM src=0 len=8 -> `result`=36 after 4 RUN cycles; SUM src=5 len=3 -> `result`=6+7+8=21 (odd tail uses port 1 only).
- Preload RAM[0..2]=11'h001, 11'h603, 11'h7FF; COPY src=0 dst=4 len=3 -> RAM[4..6] equal RAM[0..2]; overlapping COPY src=0 dst=1 len=3 -> RAM[0..3] all 11'h001.
- SUM with all words 11'h7FF, len=8 -> `result`=14'd16376, no truncation.
- Pull `reset` low during the third RUN cycle of FILL len=8 -> only 2 words written, `Write_Enable` low on the reset edge, `busy`=0 and `cmd_ready`=1 the cycle after reset releases.
- Edge commands:
  - op=11 -> `done` and `err` 1 cycle after accept, no writes.
  - len=0 -> `done` with `err`=0, no writes.
  - `cmd_valid` held during RUN -> second command not accepted until IDLE.

Source files
------------

// File: rtl/ram_access_engine.sv
// Command-driven sequencer for the 8-word dual-read/single-write datapath RAM.
// Runs FILL, COPY and SUM over wrapping address ranges and pulses done on completion.
module ram_access_engine #(
    parameter int DATA_W = 11,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [ADDR_W-1:0]        cmd_src,
    input  logic [ADDR_W-1:0]        cmd_dst,
    input  logic [ADDR_W:0]          cmd_len,
    input  logic [DATA_W-1:0]        cmd_data,
    output logic                     Write_Enable,
    output logic [ADDR_W-1:0]        Write_Address,
    output logic [DATA_W-1:0]        Write_Data,
    output logic [ADDR_W-1:0]        Read_Address_1,
    output logic [ADDR_W-1:0]        Read_Address_2,
    input  logic [DATA_W-1:0]        Read_Data_1,
    input  logic [DATA_W-1:0]        Read_Data_2,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [DATA_W+ADDR_W-1:0] result
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int RES_W = DATA_W + ADDR_W;
    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1 << ADDR_W);

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    i_q, i_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                err_q, err_d;

    logic                we_raw;
    logic [LEN_W-1:0]    i_plus1, i_plus2;
    logic [ADDR_W-1:0]   rd_addr, wr_addr;

    assign i_plus1 = i_q + LEN_W'(1);
    assign i_plus2 = i_q + LEN_W'(2);
    assign rd_addr = src_q + i_q[ADDR_W-1:0];
    assign wr_addr = dst_q + i_q[ADDR_W-1:0];

    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        op_d           = op_q;
        src_d          = src_q;
        dst_d          = dst_q;
        len_d          = len_q;
        data_d         = data_q;
        result_d       = result_q;
        err_d          = err_q;
        we_raw         = 1'b0;
        Write_Address  = '0;
        Write_Data     = '0;
        Read_Address_1 = '0;
        Read_Address_2 = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    src_d    = cmd_src;
                    dst_d    = cmd_dst;
                    len_d    = (cmd_len > DEPTH) ? DEPTH : cmd_len;
                    data_d   = cmd_data;
                    i_d      = '0;
                    result_d = '0;
                    err_d    = (cmd_op == OP_RSVD);
                    if (cmd_op == OP_RSVD || cmd_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                case (op_q)
                    OP_FILL: begin
                        we_raw        = 1'b1;
                        Write_Address = wr_addr;
                        Write_Data    = data_q;
                        i_d           = i_plus1;
                        if (i_plus1 >= len_q) state_d = DONE;
                    end
                    OP_COPY: begin
                        Read_Address_1 = rd_addr;
                        we_raw         = 1'b1;
                        Write_Address  = wr_addr;
                        Write_Data     = Read_Data_1;
                        i_d            = i_plus1;
                        if (i_plus1 >= len_q) state_d = DONE;
                    end
                    OP_SUM: begin
                        // Port 2 covers the odd word; it is dropped on an odd-length tail.
                        Read_Address_1 = rd_addr;
                        Read_Address_2 = rd_addr + ADDR_W'(1);
                        result_d = result_q + RES_W'(Read_Data_1)
                                 + ((i_plus1 < len_q) ? RES_W'(Read_Data_2) : {RES_W{1'b0}});
                        i_d      = i_plus2;
                        if (i_plus2 >= len_q) state_d = DONE;
                    end
                    default: state_d = DONE;
                endcase
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            op_q     <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            op_q     <= op_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            data_q   <= data_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Gate the strobe with reset so an interrupted run never commits a write.
    assign Write_Enable = we_raw & reset;
    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign err          = err_q;
    assign result       = result_q;

endmodule

// File: tb/tb_ram_access_engine.sv
// Scoreboard bench for ram_access_engine with a behavioural 8x11 RAM and reference model.
module tb_ram_access_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_src, cmd_dst;
    logic [3:0]  cmd_len;
    logic [10:0] cmd_data;
    logic        Write_Enable;
    logic [2:0]  Write_Address;
    logic [10:0] Write_Data;
    logic [2:0]  Read_Address_1, Read_Address_2;
    logic [10:0] Read_Data_1, Read_Data_2;
    logic        busy, done, err;
    logic [13:0] result;

    logic        pre_we;
    logic [2:0]  pre_addr;
    logic [10:0] pre_data;
    logic [10:0] ram [8];
    logic [10:0] ref_mem [8];

    typedef struct {
        int          lat;
        logic [13:0] res;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    ram_access_engine #(.DATA_W(11), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_data(cmd_data), .Write_Enable(Write_Enable), .Write_Address(Write_Address),
        .Write_Data(Write_Data), .Read_Address_1(Read_Address_1),
        .Read_Address_2(Read_Address_2), .Read_Data_1(Read_Data_1),
        .Read_Data_2(Read_Data_2), .busy(busy), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (Write_Enable) ram[Write_Address] <= Write_Data;
    end
    assign Read_Data_1 = ram[Read_Address_1];
    assign Read_Data_2 = ram[Read_Address_2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input int k, input logic [10:0] v);
        pre_we = 1'b1;
        pre_addr = 3'(k);
        pre_data = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_mem[k] = v;
    endtask

    // Reference behaviour: sequential word-by-word semantics on ref_mem.
    task automatic model(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [3:0] len_in, input logic [10:0] data, output exp_t e);
        int len = (len_in > 4'd8) ? 8 : int'(len_in);
        logic [13:0] s = '0;
        e.res = '0;
        if (op == 2'b11) begin
            e.lat = 1;
            e.err = 1'b1;
        end else begin
            e.err = 1'b0;
            if (len == 0)         e.lat = 1;
            else if (op == 2'b10) e.lat = (len + 1) / 2 + 1;
            else                  e.lat = len + 1;
            for (int k = 0; k < len; k++) begin
                case (op)
                    2'b00: ref_mem[(int'(dst) + k) % 8] = data;
                    2'b01: ref_mem[(int'(dst) + k) % 8] = ref_mem[(int'(src) + k) % 8];
                    default: s = s + 14'(ref_mem[(int'(src) + k) % 8]);
                endcase
            end
            e.res = s;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [3:0] len, input logic [10:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_data  = data;
    endtask

    task automatic wait_done();
        int cyc = 1;
        exp_t e;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        chk("done_seen", done, 1);
        chk("latency", cyc, e.lat);
        chk("err", err, e.err);
        chk("result", result, e.res);
        for (int k = 0; k < 8; k++) chk($sformatf("ram%0d", k), ram[k], ref_mem[k]);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                           input logic [3:0] len, input logic [10:0] data);
        exp_t e;
        wait_ready();
        model(op, src, dst, len, data, e);
        sb.push_back(e);
        drive(op, src, dst, len, data);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t ea, eb;
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_data = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_we", Write_Enable, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", cmd_ready, 1);

        // FILL with wrap
        for (int k = 0; k < 8; k++) preload(k, 11'h0A0 + 11'(k));
        run_cmd(2'b00, 3'd0, 3'd6, 4'd4, 11'h5A5);

        // SUM even and odd lengths
        for (int k = 0; k < 8; k++) preload(k, 11'(k + 1));
        run_cmd(2'b10, 3'd0, 3'd0, 4'd8, 11'h0);
        chk("sum36", result, 36);
        run_cmd(2'b10, 3'd5, 3'd0, 4'd3, 11'h0);
        chk("sum21", result, 21);

        // COPY disjoint and overlapping
        preload(0, 11'h001); preload(1, 11'h603); preload(2, 11'h7FF);
        run_cmd(2'b01, 3'd0, 3'd4, 4'd3, 11'h0);
        run_cmd(2'b01, 3'd0, 3'd1, 4'd3, 11'h0);
        chk("ovl_ram3", ram[3], 11'h001);

        // SUM at full scale
        for (int k = 0; k < 8; k++) preload(k, 11'h7FF);
        run_cmd(2'b10, 3'd3, 3'd0, 4'd8, 11'h0);
        chk("sum_max", result, 16376);

        // Edge commands: reserved op, zero length, clamped length
        run_cmd(2'b11, 3'd1, 3'd2, 4'd5, 11'h123);
        run_cmd(2'b00, 3'd0, 3'd2, 4'd0, 11'h321);
        run_cmd(2'b00, 3'd0, 3'd3, 4'd12, 11'h0F0);

        // cmd_valid held through RUN: second command waits for IDLE
        wait_ready();
        model(2'b00, 3'd0, 3'd0, 4'd3, 11'h111, ea);
        sb.push_back(ea);
        model(2'b10, 3'd0, 3'd0, 4'd3, 11'h0, eb);
        sb.push_back(eb);
        drive(2'b00, 3'd0, 3'd0, 4'd3, 11'h111);
        @(posedge clk); #1;
        drive(2'b10, 3'd0, 3'd0, 4'd3, 11'h0);
        chk("held_ready_run", cmd_ready, 0);
        chk("held_busy", busy, 1);
        wait_done();
        chk("held_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done();
        chk("held_sum", result, 14'h333);

        // Reset during the third RUN cycle of a FILL
        for (int k = 0; k < 8; k++) preload(k, 11'h000);
        wait_ready();
        drive(2'b00, 3'd0, 3'd0, 4'd8, 11'h2AA);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_we", Write_Enable, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        ref_mem[0] = 11'h2AA;
        ref_mem[1] = 11'h2AA;
        @(posedge clk); #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_ram%0d", k), ram[k], ref_mem[k]);

        // Random mix
        for (int k = 0; k < 8; k++) preload(k, 11'($urandom_range(0, 2047)));
        for (int t = 0; t < 12; t++) begin
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 10)), 11'($urandom_range(0, 2047)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
